// File: rtl/tl_sched_cntr_pkg.sv
// Shared definitions for the timed traffic-light scheduler: light codes,
// FSM state encoding and the state-to-lights decode.
package tl_sched_cntr_pkg;

  localparam logic [1:0] TL_GREEN  = 2'b00;
  localparam logic [1:0] TL_YELLOW = 2'b01;
  localparam logic [1:0] TL_RED    = 2'b10;

  typedef enum logic [2:0] {
    AG   = 3'd0,
    AY   = 3'd1,
    AR1  = 3'd2,
    BG   = 3'd3,
    BY   = 3'd4,
    AR2  = 3'd5,
    WALK = 3'd6
  } tl_state_e;

  typedef struct packed {
    logic [1:0] la;
    logic [1:0] lb;
    logic       walk;
  } tl_out_t;

  // Moore decode of a state into road lights and walk signal
  function automatic tl_out_t tl_decode(tl_state_e s);
    tl_out_t o;
    o = '{la: TL_RED, lb: TL_RED, walk: 1'b0};
    case (s)
      AG:      o.la = TL_GREEN;
      AY:      o.la = TL_YELLOW;
      BG:      o.lb = TL_GREEN;
      BY:      o.lb = TL_YELLOW;
      WALK:    o.walk = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/tl_sched_cntr_timer.sv
// tl_timer: CNT_W-bit saturating up-counter with synchronous clear and
// asynchronous active-high reset.
module tl_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // count up each cycle, stick at all-ones, restart on clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (cnt != '1)
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/tl_sched_cntr.sv
// tl_sched_cntr: timed two-road traffic light scheduler with pedestrian walk
// phase. Optional all-red clearance after each yellow: define TL_ALL_RED_EN.
module tl_sched_cntr
  import tl_sched_cntr_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 2,
  parameter int WALK_CYC   = 4,
  parameter int ALLRED_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       ped_req,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       walk,
  output logic       ped_ack
);

  tl_state_e        state, nxt;
  logic [CNT_W-1:0] timer, limit;
  logic             done, tmr_clr, ped_pend;
  tl_out_t          dec_nxt;

  tl_timer #(.CNT_W(CNT_W)) u_timer (
    .clk (clk),
    .rst (reset),
    .clr (tmr_clr),
    .cnt (timer)
  );

  // terminal count of the current state; >= so a saturated hold in green
  // still counts as minimum green elapsed
  always_comb begin
    limit = CNT_W'(GREEN_CYC - 1);
    case (state)
      AY, BY:   limit = CNT_W'(YELLOW_CYC - 1);
      WALK:     limit = CNT_W'(WALK_CYC - 1);
      AR1, AR2: limit = CNT_W'(ALLRED_CYC - 1);
      default:  limit = CNT_W'(GREEN_CYC - 1);
    endcase
    done = (timer >= limit);
  end

  // next-state selection
  always_comb begin
    nxt = state;
    case (state)
      AG:   if (done && (!Ta || Tb || ped_pend)) nxt = AY;
      BG:   if (done && (!Tb || Ta || ped_pend)) nxt = BY;
      WALK: if (done) nxt = AG;
`ifdef TL_ALL_RED_EN
      AY:   if (done) nxt = AR1;
      AR1:  if (done) nxt = BG;
      BY:   if (done) nxt = AR2;
      AR2:  if (done) nxt = ped_pend ? WALK : AG;
`else
      AY:   if (done) nxt = BG;
      BY:   if (done) nxt = ped_pend ? WALK : AG;
`endif
      default: nxt = AG;
    endcase
    tmr_clr = (nxt != state);
    dec_nxt = tl_decode(nxt);
  end

  // state, pedestrian pending flag and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= AG;
      ped_pend <= 1'b0;
      La       <= TL_GREEN;
      Lb       <= TL_RED;
      walk     <= 1'b0;
      ped_ack  <= 1'b0;
    end else begin
      state   <= nxt;
      La      <= dec_nxt.la;
      Lb      <= dec_nxt.lb;
      walk    <= dec_nxt.walk;
      ped_ack <= (nxt == WALK) && (state != WALK);
      if ((nxt == WALK) && (state != WALK))
        ped_pend <= 1'b0;
      else if (ped_req && (state != WALK))
        ped_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tl_sched_cntr.sv
// Directed self-checking bench for tl_sched_cntr (default parameters).
module tb_tl_sched_cntr;

`ifdef TL_ALL_RED_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif
  localparam int P = 20 + 2 * AR;

  localparam logic [4:0] E_AG   = 5'b00100;
  localparam logic [4:0] E_AY   = 5'b01100;
  localparam logic [4:0] E_BG   = 5'b10000;
  localparam logic [4:0] E_BY   = 5'b10010;
  localparam logic [4:0] E_AR   = 5'b10100;
  localparam logic [4:0] E_WALK = 5'b10101;

  logic       clk = 1'b0;
  logic       reset, Ta, Tb, ped_req;
  logic [1:0] La, Lb;
  logic       walk, ped_ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tl_sched_cntr #(
    .CNT_W(4), .GREEN_CYC(8), .YELLOW_CYC(2), .WALK_CYC(4), .ALLRED_CYC(1)
  ) dut (
    .clk(clk), .reset(reset), .Ta(Ta), .Tb(Tb), .ped_req(ped_req),
    .La(La), .Lb(Lb), .walk(walk), .ped_ack(ped_ack)
  );

  // expected {La,Lb,walk} at sample i of an undisturbed cycle
  function automatic logic [4:0] exp_cycle(int i);
    int k;
    k = i % P;
    if (k < 8) return E_AG;
    if (k < 10) return E_AY;
    if (k < 10 + AR) return E_AR;
    if (k < 18 + AR) return E_BG;
    if (k < 20 + AR) return E_BY;
    return E_AR;
  endfunction

  // expected outputs when a walk follows the first B phase
  function automatic logic [4:0] exp_ped(int i);
    if (i < P) return exp_cycle(i);
    if (i < P + 4) return E_WALK;
    return exp_cycle(i - P - 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic a, input logic b);
    reset = 1'b1; Ta = a; Tb = b; ped_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Ta = 1'b0; Tb = 1'b0; ped_req = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({La, Lb, walk} !== E_AG) begin
        bad++; $display("FAIL reset_lights i=%0d got=%b exp=%b", i, {La, Lb, walk}, E_AG);
      end
      total++;
      if (ped_ack !== 1'b0) begin
        bad++; $display("FAIL reset_ack i=%0d got=%b exp=0", i, ped_ack);
      end
      tick();
    end
  endtask

  task automatic test_free_run();
    start(1'b0, 1'b0);
    for (int i = 0; i < 2 * P + 2; i++) begin
      total++;
      if ({La, Lb, walk} !== exp_cycle(i)) begin
        bad++; $display("FAIL free_run s=%0d got=%b exp=%b", i, {La, Lb, walk}, exp_cycle(i));
      end
      tick();
    end
  endtask

  task automatic test_hold_a();
    logic [4:0] e;
    start(1'b1, 1'b0);
    for (int i = 0; i < 42; i++) begin
      if (i < 30) e = E_AG;
      else if (i < 32) e = E_AY;
      else if (i < 32 + AR) e = E_AR;
      else if (i < 40 + AR) e = E_BG;
      else e = E_BY;
      total++;
      if ({La, Lb, walk} !== e) begin
        bad++; $display("FAIL hold_a s=%0d got=%b exp=%b", i, {La, Lb, walk}, e);
      end
      if (i == 29) Tb = 1'b1;
      tick();
    end
    Ta = 1'b0; Tb = 1'b0;
  endtask

  task automatic test_ped();
    start(1'b0, 1'b0);
    for (int i = 0; i < P + 30; i++) begin
      total++;
      if ({La, Lb, walk} !== exp_ped(i)) begin
        bad++; $display("FAIL ped_seq s=%0d got=%b exp=%b", i, {La, Lb, walk}, exp_ped(i));
      end
      total++;
      if (ped_ack !== (i == P)) begin
        bad++; $display("FAIL ped_ack s=%0d got=%b exp=%b", i, ped_ack, (i == P));
      end
      ped_req = (i == 2) || (i == 5) || (i == P + 1);
      tick();
    end
    ped_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    start(1'b0, 1'b0);
    for (int i = 0; i < 2 * P + 6; i++) begin
      e = (i < P) ? exp_cycle(i) : exp_ped(i - P);
      total++;
      if ({La, Lb, walk} !== e) begin
        bad++; $display("FAIL by_exit_race s=%0d got=%b exp=%b", i, {La, Lb, walk}, e);
      end
      total++;
      if (ped_ack !== (i == 2 * P)) begin
        bad++; $display("FAIL by_exit_ack s=%0d got=%b exp=%b", i, ped_ack, (i == 2 * P));
      end
      ped_req = (i == P - 1);
      tick();
    end
    ped_req = 1'b0;
  endtask

  task automatic test_reset_mid(input int stop, input logic [4:0] at_stop);
    start(1'b0, 1'b0);
    for (int i = 0; i < stop; i++) begin
      ped_req = (i == 2);
      tick();
    end
    ped_req = 1'b0;
    total++;
    if ({La, Lb, walk} !== at_stop) begin
      bad++; $display("FAIL mid_pre s=%0d got=%b exp=%b", stop, {La, Lb, walk}, at_stop);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({La, Lb, walk, ped_ack} !== {E_AG, 1'b0}) begin
      bad++; $display("FAIL mid_async s=%0d got=%b exp=%b", stop, {La, Lb, walk, ped_ack}, {E_AG, 1'b0});
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < P + 6; i++) begin
      total++;
      if ({La, Lb, walk, ped_ack} !== {exp_cycle(i), 1'b0}) begin
        bad++; $display("FAIL mid_after s=%0d got=%b exp=%b", i, {La, Lb, walk, ped_ack}, {exp_cycle(i), 1'b0});
      end
      tick();
    end
  endtask

  task automatic test_both_busy();
    start(1'b1, 1'b1);
    for (int i = 0; i < 2 * P + 2; i++) begin
      total++;
      if ({La, Lb, walk} !== exp_cycle(i)) begin
        bad++; $display("FAIL both_busy s=%0d got=%b exp=%b", i, {La, Lb, walk}, exp_cycle(i));
      end
      tick();
    end
    Ta = 1'b0; Tb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_hold_a();
    test_ped();
    test_back_to_back();
    test_reset_mid(P - 2, E_BY);
    test_reset_mid(P + 1, E_WALK);
    test_both_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
